// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD raster timing generator with a pixel source that is
// either an external RGB888/RGB565 stream or an internal test pattern
// (colour bars or a solid colour). Sync and colour outputs are registered
// one clock after the counters that produce them.
module lcd_timing_gen #(
   parameter int unsigned H_ACTIVE  = 800,
   parameter int unsigned H_BLANK   = 46,
   parameter int unsigned H_FRONT   = 210,
   parameter int unsigned H_SYNC_W  = 1,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_BLANK   = 23,
   parameter int unsigned V_FRONT   = 22,
   parameter int unsigned V_SYNC_W  = 1,
   parameter int unsigned LOOKAHEAD = 2,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic [1:0]  iMode,
   input  logic [23:0] iSolid,
   input  logic [31:0] iPIX_DATA,
   input  logic        iPIX_VALID,
   output logic        oPIX_REQ,
   output logic [10:0] oNext_X,
   output logic [9:0]  oNext_Y,
   output logic        oNew_Frame,
   output logic        oEnd_Frame,
   output logic        oUnderflow,
   output logic [15:0] oFrame_Count,
   output logic        oHD,
   output logic        oVD,
   output logic [7:0]  oLCD_R,
   output logic [7:0]  oLCD_G,
   output logic [7:0]  oLCD_B
);

   localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE + V_FRONT;
   localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   // Wider widths so that end-of-region bounds and lookahead sums never wrap.
   localparam int unsigned HSW     = HW + 4;
   localparam int unsigned VSW     = VW + 1;
   localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

   localparam logic [1:0] MODE_RGB888 = 2'd0;
   localparam logic [1:0] MODE_RGB565 = 2'd1;
   localparam logic [1:0] MODE_BARS   = 2'd2;

   logic [HW-1:0]  r_h_cnt;
   logic [VW-1:0]  r_v_cnt;
   logic [1:0]     r_mode;

   logic           w_h_last;
   logic           w_v_last;
   logic           w_frame_start;
   logic           w_h_act;
   logic           w_v_act;
   logic           w_active;
   logic           w_stream;
   logic           w_underflow;
   logic [HW-1:0]  w_x;
   logic [2:0]     w_bar;
   logic [23:0]    w_bar_rgb;
   logic [23:0]    w_rgb565;
   logic [23:0]    w_rgb;
   logic [HSW-1:0] w_h_sum;
   logic [HW-1:0]  w_nh;
   logic [VW-1:0]  w_nv;
   logic           w_carry;
   logic           w_nh_act;
   logic           w_nv_act;
   logic           w_unused;

   // Position decode of the current raster counters.
   assign w_h_last      = (r_h_cnt == HW'(H_TOTAL - 1));
   assign w_v_last      = (r_v_cnt == VW'(V_TOTAL - 1));
   assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign w_h_act       = (HSW'(r_h_cnt) >= HSW'(H_BLANK)) &&
                          (HSW'(r_h_cnt) <  HSW'(H_BLANK + H_ACTIVE));
   assign w_v_act       = (VSW'(r_v_cnt) >= VSW'(V_BLANK)) &&
                          (VSW'(r_v_cnt) <  VSW'(V_BLANK + V_ACTIVE));
   assign w_active      = w_h_act && w_v_act;

   // Pixel request handshake: only the streaming modes pull pixels.
   assign w_stream    = (r_mode == MODE_RGB888) || (r_mode == MODE_RGB565);
   assign oPIX_REQ    = w_active && w_stream;
   assign w_underflow = oPIX_REQ && !iPIX_VALID;

   // Frame markers.
   assign oNew_Frame = w_frame_start;
   assign oEnd_Frame = (r_h_cnt == HW'(H_BLANK + H_ACTIVE - 1)) &&
                       (r_v_cnt == VW'(V_BLANK + V_ACTIVE - 1));

   // The top byte of the pixel word carries no colour information.
   assign w_unused = ^iPIX_DATA[31:24];

   // Horizontal and vertical raster counters.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_last) begin
         r_h_cnt <= '0;
         if (w_v_last) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + VW'(1);
         end
      end else begin
         r_h_cnt <= r_h_cnt + HW'(1);
      end
   end

   // Mode is sampled only at the frame origin so a frame never mixes sources.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_mode <= iMode;
      end else if (w_frame_start) begin
         r_mode <= iMode;
      end
   end

   // Colour-bar index: last bar absorbs any remainder of H_ACTIVE / 8.
   always_comb begin
      w_x   = r_h_cnt - HW'(H_BLANK);
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (32'(w_x) >= (32'(k) * BAR_W)) begin
            w_bar = 3'(k);
         end
      end
   end

   // Colour-bar palette, left to right.
   always_comb begin
      w_bar_rgb = 24'h000000;
      case (w_bar)
         3'd0:    w_bar_rgb = 24'hFFFFFF;
         3'd1:    w_bar_rgb = 24'hFFFF00;
         3'd2:    w_bar_rgb = 24'h00FFFF;
         3'd3:    w_bar_rgb = 24'h00FF00;
         3'd4:    w_bar_rgb = 24'hFF00FF;
         3'd5:    w_bar_rgb = 24'hFF0000;
         3'd6:    w_bar_rgb = 24'h0000FF;
         default: w_bar_rgb = 24'h000000;
      endcase
   end

   // RGB565 to RGB888 by replicating the top bits into the low bits.
   assign w_rgb565 = {iPIX_DATA[15:11], iPIX_DATA[15:13],
                      iPIX_DATA[10:5],  iPIX_DATA[10:9],
                      iPIX_DATA[4:0],   iPIX_DATA[4:2]};

   // Pixel colour for the current position; blanking and starvation give black.
   always_comb begin
      w_rgb = 24'h000000;
      if (w_active && !w_underflow) begin
         case (r_mode)
            MODE_RGB888: w_rgb = iPIX_DATA[23:0];
            MODE_RGB565: w_rgb = w_rgb565;
            MODE_BARS:   w_rgb = w_bar_rgb;
            default:     w_rgb = iSolid;
         endcase
      end
   end

   // Registered sync and colour outputs.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oHD    <= ~SYNC_POL;
         oVD    <= ~SYNC_POL;
         oLCD_R <= 8'h00;
         oLCD_G <= 8'h00;
         oLCD_B <= 8'h00;
      end else begin
         oHD    <= (HSW'(r_h_cnt) < HSW'(H_SYNC_W)) ? SYNC_POL : ~SYNC_POL;
         oVD    <= (VSW'(r_v_cnt) < VSW'(V_SYNC_W)) ? SYNC_POL : ~SYNC_POL;
         oLCD_R <= w_rgb[23:16];
         oLCD_G <= w_rgb[15:8];
         oLCD_B <= w_rgb[7:0];
      end
   end

   // Sticky starvation flag, cleared leaving the frame origin; a new underflow wins.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oUnderflow <= 1'b0;
      end else if (w_underflow) begin
         oUnderflow <= 1'b1;
      end else if (w_frame_start) begin
         oUnderflow <= 1'b0;
      end
   end

   // Completed-frame counter, bumped as the raster wraps back to the origin.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oFrame_Count <= 16'd0;
      end else if (w_h_last && w_v_last) begin
         oFrame_Count <= oFrame_Count + 16'd1;
      end
   end

   // Lookahead position: advance h by LOOKAHEAD, carrying into the line count.
   always_comb begin
      w_h_sum = HSW'(r_h_cnt) + HSW'(LOOKAHEAD);
      w_carry = 1'b0;
      w_nh    = HW'(w_h_sum);
      w_nv    = r_v_cnt;
      if (w_h_sum >= HSW'(H_TOTAL)) begin
         w_carry = 1'b1;
         w_nh    = HW'(w_h_sum - HSW'(H_TOTAL));
      end
      if (w_carry) begin
         w_nv = w_v_last ? '0 : (r_v_cnt + VW'(1));
      end
   end

   // Lookahead coordinates relative to the active area, zero outside it.
   assign w_nh_act = (HSW'(w_nh) >= HSW'(H_BLANK)) &&
                     (HSW'(w_nh) <  HSW'(H_BLANK + H_ACTIVE));
   assign w_nv_act = (VSW'(w_nv) >= VSW'(V_BLANK)) &&
                     (VSW'(w_nv) <  VSW'(V_BLANK + V_ACTIVE));
   assign oNext_X  = w_nh_act ? 11'(w_nh - HW'(H_BLANK)) : 11'd0;
   assign oNext_Y  = w_nv_act ? 10'(w_nv - VW'(V_BLANK)) : 10'd0;

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The module SHALL have parameter H_BLANK, default 46, sync plus back-porch clocks before active video.
REQ-003 The module SHALL have parameter H_FRONT, default 210, front-porch clocks after active video.
REQ-004 The module SHALL have parameter H_SYNC_W, default 1, HSYNC pulse width in clocks (1 <= H_SYNC_W <= H_BLANK).
REQ-005 The module SHALL have parameters V_ACTIVE, default 480; V_BLANK, default 23; V_FRONT, default 22; and V_SYNC_W, default 1; these are the vertical equivalents, in lines.
REQ-006 The module SHALL have parameter LOOKAHEAD, default 2, range 1..4, the clocks of lead of oNext_X/oNext_Y over the counter.
REQ-007 The module SHALL have parameter SYNC_POL, default 0, the sync level during the pulse.
REQ-008 Port iCLK SHALL be an input, 1 bit, the pixel clock.
REQ-009 Port iRST_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-010 Port iMode SHALL be an input, 2 bits: 0 = stream RGB888, 1 = stream RGB565, 2 = colour bars, 3 = solid colour.
REQ-011 Port iSolid SHALL be an input, 24 bits, the RGB888 colour for mode 3.
REQ-012 Ports iPIX_DATA (input, 32 bits, pixel word) and iPIX_VALID (input, 1 bit, pixel word available) SHALL exist.
REQ-013 Port oPIX_REQ SHALL be an output, 1 bit: a pixel is consumed this cycle if iPIX_VALID is high.
REQ-014 Ports oNext_X (output, 11 bits) and oNext_Y (output, 10 bits) SHALL give the active-area coordinates LOOKAHEAD clocks ahead.
REQ-015 Ports oNew_Frame and oEnd_Frame SHALL be outputs, 1 bit each, single-cycle frame pulses.
REQ-016 Port oUnderflow SHALL be an output, 1 bit, a per-frame sticky starvation flag.
REQ-017 Port oFrame_Count SHALL be an output, 16 bits, the count of completed frames.
REQ-018 Ports oHD, oVD and oLCD_R/G/B SHALL be outputs of 1, 1 and 8 bits each, the registered LCD sync and colour signals.

Function
REQ-019 h_cnt SHALL run 0..H_TOTAL-1 and wrap to 0, where H_TOTAL = H_BLANK + H_ACTIVE + H_FRONT; v_cnt SHALL advance on the h_cnt wrap, run 0..V_TOTAL-1 and wrap to 0.
REQ-020 "Active" SHALL mean H_BLANK <= h_cnt < H_BLANK + H_ACTIVE and V_BLANK <= v_cnt < V_BLANK + V_ACTIVE.
REQ-021 oPIX_REQ SHALL be a combinational function of the counters and the latched mode: high iff active and the latched mode is 0 or 1.
REQ-022 Output latency SHALL be 1 clock: oHD, oVD and oLCD_* register values computed from the current h_cnt/v_cnt.
REQ-023 oHD SHALL register SYNC_POL when h_cnt < H_SYNC_W and ~SYNC_POL otherwise; oVD SHALL do the same using v_cnt and V_SYNC_W.
REQ-024 Blanking: when not active, oLCD_* SHALL register 0.
REQ-025 Mode 0: oLCD_R/G/B SHALL register iPIX_DATA[23:16], [15:8] and [7:0].
REQ-026 Mode 1: R SHALL be {d[15:11], d[15:13]}, G SHALL be {d[10:5], d[10:9]} and B SHALL be {d[4:0], d[4:2]}, where d = iPIX_DATA.
REQ-027 Mode 2: eight vertical bars of width H_ACTIVE/8 SHALL be shown, left to right white, yellow, cyan, green, magenta, red, blue, black; the last bar SHALL absorb any remainder.
REQ-028 Mode 3: the output SHALL be iSolid.
REQ-029 iMode SHALL be latched only at h_cnt = 0, v_cnt = 0 and at reset; mid-frame changes SHALL have no effect until the next frame.
REQ-030 Underflow: when oPIX_REQ is high and iPIX_VALID is low, that pixel SHALL output 0 and oUnderflow SHALL be set on the next edge.
REQ-031 oUnderflow SHALL be cleared on the edge that leaves v_cnt = 0, h_cnt = 0 unless an underflow occurs in that same cycle, in which case set SHALL win.
REQ-032 oNext_X SHALL equal (h_cnt + LOOKAHEAD) - H_BLANK, with the sum taken modulo H_TOTAL and the line/frame carry applied to the Y term.
REQ-033 oNext_X and oNext_Y SHALL each be forced to 0 when their position is outside the active area.
REQ-034 oNew_Frame SHALL be high when h_cnt = 0 and v_cnt = 0.
REQ-035 oEnd_Frame SHALL be high in the cycle of the last active pixel (h_cnt = H_BLANK + H_ACTIVE - 1, v_cnt = V_BLANK + V_ACTIVE - 1).
REQ-036 oFrame_Count SHALL increment on the edge where v_cnt wraps to 0, and SHALL wrap modulo 2^16.

Reset
REQ-037 While iRST_n is low, asynchronously: h_cnt = 0, v_cnt = 0, oLCD_* = 0, oHD = oVD = ~SYNC_POL, oUnderflow = 0, oFrame_Count = 0, and the latched mode = iMode.
REQ-038 Reset assertion mid-line SHALL abort the frame immediately; the first edge after release SHALL start at h_cnt = 0, v_cnt = 0 with oNew_Frame high.

Verification
REQ-039 Test: with H_ACTIVE=8, H_BLANK=2, H_FRONT=2, V_ACTIVE=4, V_BLANK=1, V_FRONT=1 and SYNC_POL=0, run 2 frames -> oHD is low 1 clock per 12-clock line, oVD is low 12 clocks per 72-clock frame, and oFrame_Count = 2.
REQ-040 Test: mode 0 with iPIX_VALID held high and an incrementing data value -> exactly 32 requests per frame, and oLCD values equal the requested words delayed by 1 clock.
REQ-041 Test: mode 1 with iPIX_DATA = 16'hF800 -> R=FF, G=00, B=00; with 16'h07E0 -> G=FF only.
REQ-042 Test: drop iPIX_VALID for one active pixel -> that pixel outputs 0, oUnderflow rises, and oUnderflow clears after the next frame start.
REQ-043 Test: switch iMode 0->2 mid-frame -> the stream continues until the frame ends, then bars appear with bar 0 = FFFFFF and bar 7 = 000000; oPIX_REQ stays low in mode 2.
REQ-044 Test: assert iRST_n low for 3 clocks mid-line, with LOOKAHEAD=2 -> all outputs take the reset values of REQ-037, and after release oNew_Frame pulses on the first edge.
REQ-045 Test: with LOOKAHEAD=2, check oNext_X at h_cnt = H_BLANK-2 -> oNext_X = 0 on a row inside the active area.
